// File: rtl/r4_seq_pkg.sv
// Shared definitions for the radix-4 butterfly sequencer.
//   - state_e      : sequencer FSM states
//   - SEL_BIN0..3  : butterfly select codes {c3,c2,c1} for each output bin
//   - W_DEFAULT    : default sample component width
//   - bin_sel()    : maps a 2-bit bin index to its select code
package r4_seq_pkg;

    localparam int unsigned W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2
    } state_e;

    localparam logic [2:0] SEL_BIN0 = 3'b000;
    localparam logic [2:0] SEL_BIN1 = 3'b001;
    localparam logic [2:0] SEL_BIN2 = 3'b010;
    localparam logic [2:0] SEL_BIN3 = 3'b100;

    function automatic logic [2:0] bin_sel(input logic [1:0] bin);
        logic [2:0] sel;
        unique case (bin)
            2'd0:    sel = SEL_BIN0;
            2'd1:    sel = SEL_BIN1;
            2'd2:    sel = SEL_BIN2;
            default: sel = SEL_BIN3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/r4_seq_settle_ctr.sv
// Settle down-counter for the butterfly sequencer.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset, clears the count
//   load_i  load SETTLE (takes effect on the next cycle)
//   en_i    count enable; high while the select lines are being held
//   done_o  high during the final settle cycle
module r4_seq_settle_ctr #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 4'(SETTLE);
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // A count of one means this is the last of the SETTLE cycles.
    assign done_o = en_i && (cnt_q == 4'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/r4_butter_seq.sv
// Radix-4 butterfly sequencer. Accepts one frame of four complex samples,
// holds them on the butterfly inputs, steps the select lines through bins
// 0..3 and emits each settled result on a backpressured output stream.
// Ports:
//   wb_clk_i / wb_rst_ni         clock, synchronous active-low reset
//   in_valid/in_ready/in_xr/in_xi  input frame handshake and samples
//   bf_xr/bf_xi/bf_c             registered samples and select to butterfly
//   bf_xro/bf_xio                butterfly result
//   out_valid/out_ready/out_re/out_im/out_bin/out_last  result stream
//   frm_cnt                      completed-frame counter (R4_SEQ_FRMCNT_EN only)
//   busy                         frame in progress
// Optional feature macro: R4_SEQ_FRMCNT_EN
module r4_butter_seq
    import r4_seq_pkg::*;
#(
    parameter int unsigned W      = W_DEFAULT,
    parameter int unsigned SETTLE = 1
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] in_xr,
    input  logic [4*W-1:0] in_xi,
    output logic [4*W-1:0] bf_xr,
    output logic [4*W-1:0] bf_xi,
    output logic [2:0]     bf_c,
    input  logic [W-1:0]   bf_xro,
    input  logic [W-1:0]   bf_xio,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_re,
    output logic [W-1:0]   out_im,
    output logic [1:0]     out_bin,
    output logic           out_last,
`ifdef R4_SEQ_FRMCNT_EN
    output logic [15:0]    frm_cnt,
`endif
    output logic           busy
);

    state_e         state_q, state_d;
    logic [1:0]     bin_q, bin_d;
    logic [4*W-1:0] bf_xr_q, bf_xr_d;
    logic [4*W-1:0] bf_xi_q, bf_xi_d;
    logic [W-1:0]   out_re_q, out_re_d;
    logic [W-1:0]   out_im_q, out_im_d;
    logic [1:0]     out_bin_q, out_bin_d;
    logic           out_last_q, out_last_d;
    logic           ctr_load, ctr_en, ctr_done;
`ifdef R4_SEQ_FRMCNT_EN
    logic [15:0]    frm_cnt_q, frm_cnt_d;
`endif

    r4_seq_settle_ctr #(
        .SETTLE(SETTLE)
    ) u_settle_ctr (
        .clk_i (wb_clk_i),
        .rst_ni(wb_rst_ni),
        .load_i(ctr_load),
        .en_i  (ctr_en),
        .done_o(ctr_done)
    );

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bf_xr_d    = bf_xr_q;
        bf_xi_d    = bf_xi_q;
        out_re_d   = out_re_q;
        out_im_d   = out_im_q;
        out_bin_d  = out_bin_q;
        out_last_d = out_last_q;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;
`ifdef R4_SEQ_FRMCNT_EN
        frm_cnt_d  = frm_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bf_xr_d  = in_xr;
                    bf_xi_d  = in_xi;
                    bin_d    = 2'd0;
                    ctr_load = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                ctr_en = 1'b1;
                if (ctr_done) begin
                    out_re_d   = bf_xro;
                    out_im_d   = bf_xio;
                    out_bin_d  = bin_q;
                    out_last_d = (bin_q == 2'd3);
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (bin_q == 2'd3) begin
                        state_d = IDLE;
`ifdef R4_SEQ_FRMCNT_EN
                        frm_cnt_d = frm_cnt_q + 16'd1;
`endif
                    end else begin
                        bin_d    = bin_q + 2'd1;
                        ctr_load = 1'b1;
                        state_d  = DRIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            bin_q      <= 2'd0;
            bf_xr_q    <= '0;
            bf_xi_q    <= '0;
            out_re_q   <= '0;
            out_im_q   <= '0;
            out_bin_q  <= 2'd0;
            out_last_q <= 1'b0;
`ifdef R4_SEQ_FRMCNT_EN
            frm_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bf_xr_q    <= bf_xr_d;
            bf_xi_q    <= bf_xi_d;
            out_re_q   <= out_re_d;
            out_im_q   <= out_im_d;
            out_bin_q  <= out_bin_d;
            out_last_q <= out_last_d;
`ifdef R4_SEQ_FRMCNT_EN
            frm_cnt_q  <= frm_cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == EMIT);
    assign bf_c      = (state_q == IDLE) ? SEL_BIN0 : bin_sel(bin_q);
    assign bf_xr     = bf_xr_q;
    assign bf_xi     = bf_xi_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_bin   = out_bin_q;
    assign out_last  = out_last_q;
`ifdef R4_SEQ_FRMCNT_EN
    assign frm_cnt   = frm_cnt_q;
`endif

endmodule

// File: tb/tb_r4_butter_seq.sv
// Directed self-checking bench for r4_butter_seq (W=4, SETTLE=1).
module tb_r4_butter_seq;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] in_xr, in_xi;
    logic [4*W-1:0] bf_xr, bf_xi;
    logic [2:0]     bf_c;
    logic [W-1:0]   bf_xro, bf_xio;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_re, out_im;
    logic [1:0]     out_bin;
    logic           out_last;
    logic           busy;
`ifdef R4_SEQ_FRMCNT_EN
    logic [15:0]    frm_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Butterfly stand-in: result encodes the select lines.
    assign bf_xro = {1'b0, bf_c};
    assign bf_xio = ~{1'b0, bf_c};

    r4_butter_seq #(
        .W     (W),
        .SETTLE(1)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_xr    (in_xr),
        .in_xi    (in_xi),
        .bf_xr    (bf_xr),
        .bf_xi    (bf_xi),
        .bf_c     (bf_c),
        .bf_xro   (bf_xro),
        .bf_xio   (bf_xio),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_bin  (out_bin),
        .out_last (out_last),
`ifdef R4_SEQ_FRMCNT_EN
        .frm_cnt  (frm_cnt),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs a whole frame with out_ready high; returns number of results seen.
    task automatic run_frame(input logic [15:0] xr, input logic [15:0] xi, output int got);
        got = 0;
        in_xr     = xr;
        in_xi     = xi;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && got < 4; i++) begin
            if (out_valid) got++;
            step();
        end
    endtask

    logic [3:0] exp_re [4];
    logic [3:0] exp_im [4];
    logic [2:0] exp_c  [4];
    int         got;

    initial begin
        exp_re = '{4'h0, 4'h1, 4'h2, 4'h4};
        exp_im = '{4'hF, 4'hE, 4'hD, 4'hB};
        exp_c  = '{3'b000, 3'b001, 3'b010, 3'b100};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_xr     = '0;
        in_xi     = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bf_c", bf_c, 0);
        check("rst_busy", busy, 0);
        check("rst_bf_xr", bf_xr, 0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", in_ready, 1);

        // Frame 1: handshake at cycle T.
        in_xr     = 16'h4321;
        in_xi     = 16'h8765;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();  // T+1
        in_valid = 1'b0;
        check("f1_bf_xr", bf_xr, 16'h4321);
        check("f1_bf_xi", bf_xi, 16'h8765);
        check("f1_in_ready_drive", in_ready, 0);
        check("f1_busy", busy, 1);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) step();
            check($sformatf("f1_drive%0d_valid", b), out_valid, 0);
            check($sformatf("f1_drive%0d_bf_c", b), bf_c, exp_c[b]);
            step();
            check($sformatf("f1_emit%0d_valid", b), out_valid, 1);
            check($sformatf("f1_emit%0d_re", b), out_re, exp_re[b]);
            check($sformatf("f1_emit%0d_im", b), out_im, exp_im[b]);
            check($sformatf("f1_emit%0d_bin", b), out_bin, b);
            check($sformatf("f1_emit%0d_last", b), out_last, (b == 3) ? 1 : 0);
        end
        step();  // T+9
        check("f1_in_ready_t9", in_ready, 1);
        check("f1_busy_t9", busy, 0);
        check("f1_bf_c_t9", bf_c, 0);
        check("f1_out_valid_t9", out_valid, 0);
`ifdef R4_SEQ_FRMCNT_EN
        check("f1_frm_cnt", frm_cnt, 1);
`endif

        // Frame 2: ignored input during DRIVE, then backpressure in bin1.
        in_xr    = 16'h1234;
        in_xi    = 16'h5678;
        in_valid = 1'b1;
        step();  // T+1 DRIVE bin0
        in_valid = 1'b0;
        step();  // T+2 EMIT bin0, handshake
        check("f2_emit0_valid", out_valid, 1);
        step();  // T+3 DRIVE bin1
        in_valid  = 1'b1;
        in_xr     = 16'hFFFF;
        in_xi     = 16'hFFFF;
        out_ready = 1'b0;
        check("f2_drive_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp%0d_valid", i), out_valid, 1);
            check($sformatf("bp%0d_re", i), out_re, 1);
            check($sformatf("bp%0d_bf_c", i), bf_c, 3'b001);
            check($sformatf("bp%0d_bf_xr", i), bf_xr, 16'h1234);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();  // DRIVE bin2
        check("bp_release_valid", out_valid, 0);
        check("bp_release_bf_c", bf_c, 3'b010);
        out_ready = 1'b0;
        step();  // EMIT bin2
        check("f2_emit2_re", out_re, 2);
        check("f2_emit2_bin", out_bin, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_bf_c", bf_c, 0);
        check("mrst_bf_xr", bf_xr, 0);
        check("mrst_bf_xi", bf_xi, 0);
        check("mrst_out_re", out_re, 0);
        check("mrst_out_im", out_im, 0);
        check("mrst_out_bin", out_bin, 0);
        check("mrst_out_last", out_last, 0);
`ifdef R4_SEQ_FRMCNT_EN
        check("mrst_frm_cnt", frm_cnt, 0);
`endif

        // Frame 3 after reset starts at bin 0.
        in_xr    = 16'h0AAA;
        in_xi    = 16'h0555;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("f3_bf_xr", bf_xr, 16'h0AAA);
        check("f3_bf_c", bf_c, 0);
        step();
        check("f3_emit0_valid", out_valid, 1);
        check("f3_emit0_bin", out_bin, 0);
        check("f3_emit0_re", out_re, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) step();
        check("f3_done", in_ready, 1);

        run_frame(16'h1111, 16'h2222, got);
        check("f4_results", got, 4);

`ifdef R4_SEQ_FRMCNT_EN
        check("f4_frm_cnt", frm_cnt, 2);
        force dut.frm_cnt_q = 16'hFFFF;
        step();
        release dut.frm_cnt_q;
        step();
        check("preload_frm_cnt", frm_cnt, 16'hFFFF);
        run_frame(16'h3333, 16'h4444, got);
        check("wrap_results", got, 4);
        check("wrap_frm_cnt", frm_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
